// File: rtl/wt_div_pkg.sv
// Shared types and sizing for the WT16 restoring divider.
// Define WT_DIV_RADIX4_EN to retire two quotient bits per step (radix-4).
package wt_div_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int unsigned N_DEF = 16;

`ifdef WT_DIV_RADIX4_EN
   localparam int unsigned RADIX_BITS = 2;
`else
   localparam int unsigned RADIX_BITS = 1;
`endif

   localparam int unsigned STEPS = N_DEF / RADIX_BITS;
   localparam int unsigned CNT_W = $clog2(N_DEF) + 1;

   function automatic int unsigned steps_for(input int unsigned n);
      return n / RADIX_BITS;
   endfunction

endpackage

// File: rtl/wt_div_step.sv
// One combinational restoring-division step: radix-2 (BITS=1) or radix-4 (BITS=2).
// Requires r_in < b; guarantees r_out < b.
module wt_div_step #(
   parameter int unsigned N    = 16,
   parameter int unsigned BITS = 1
) (
   input  logic [N-1:0]    r_in,
   input  logic [N-1:0]    b,
   input  logic [BITS-1:0] d,
   output logic [N-1:0]    r_out,
   output logic [BITS-1:0] qbits
);

   if (BITS == 2) begin : g_radix4
      logic [N+1:0] s, b1, b2, b3;
      always_comb begin
         s     = {r_in, d};
         b1    = {2'b00, b};
         b2    = {1'b0, b, 1'b0};
         b3    = b1 + b2;
         qbits = 2'd0;
         r_out = N'(s);
         // s < 4B always, so the largest fitting multiple leaves r_out < B
         if (s >= b3) begin
            qbits = 2'd3;
            r_out = N'(s - b3);
         end else if (s >= b2) begin
            qbits = 2'd2;
            r_out = N'(s - b2);
         end else if (s >= b1) begin
            qbits = 2'd1;
            r_out = N'(s - b1);
         end
      end
   end else begin : g_radix2
      logic [N:0] s;
      always_comb begin
         s     = {r_in, d};
         qbits = '0;
         r_out = N'(s);
         if (s >= {1'b0, b}) begin
            qbits = '1;
            r_out = N'(s - {1'b0, b});
         end
      end
   end

endmodule

// File: rtl/wt16_divider.sv
// Sequential unsigned 2N/N restoring divider with valid/ready handshakes.
// Radix selected by WT_DIV_RADIX4_EN (latency N/2 when defined, N otherwise).
module wt16_divider
   import wt_div_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] in_p,
   input  logic [N-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_q,
   output logic [N-1:0]   out_r,
   output logic           out_dbz,
   output logic           out_ovf
);

   localparam int unsigned BITS    = RADIX_BITS;
   localparam int unsigned STEPS_L = steps_for(N);
   localparam int unsigned CW      = $clog2(N) + 1;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   rem, rem_nx, div_b, dv, qacc, q_nx;
   logic [BITS-1:0] qb;
   logic           accept, err_dbz, err_ovf, last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   wt_div_step #(.N(N), .BITS(BITS)) u_step (
      .r_in  (rem),
      .b     (div_b),
      .d     (dv[N-1 -: BITS]),
      .r_out (rem_nx),
      .qbits (qb)
   );

   always_comb begin
      accept   = in_valid && (state == IDLE);
      err_dbz  = (in_b == '0);
      err_ovf  = !err_dbz && (in_p[2*N-1:N] >= in_b);
      last     = (cnt == CW'(1));
      q_nx     = N'({qacc, qb});
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (err_dbz || err_ovf) ? DONE : RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         rem     <= '0;
         div_b   <= '0;
         dv      <= '0;
         qacc    <= '0;
         out_q   <= '0;
         out_r   <= '0;
         out_dbz <= 1'b0;
         out_ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               div_b <= in_b;
               dv    <= in_p[N-1:0];
               rem   <= in_p[2*N-1:N];
               qacc  <= '0;
               cnt   <= CW'(STEPS_L);
               if (err_dbz) begin
                  out_q   <= '1;
                  out_r   <= in_p[N-1:0];
                  out_dbz <= 1'b1;
                  out_ovf <= 1'b0;
               end else if (err_ovf) begin
                  out_q   <= '1;
                  out_r   <= '0;
                  out_dbz <= 1'b0;
                  out_ovf <= 1'b1;
               end
            end
            RUN: begin
               rem  <= rem_nx;
               dv   <= dv << BITS;
               qacc <= q_nx;
               cnt  <= cnt - CW'(1);
               if (last) begin
                  out_q   <= q_nx;
                  out_r   <= rem_nx;
                  out_dbz <= 1'b0;
                  out_ovf <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wt16_divider.sv
// Directed and randomised self-checking bench for wt16_divider.
// Honours WT_DIV_RADIX4_EN for the expected latency.
module tb_wt16_divider;

`ifdef WT_DIV_RADIX4_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 16;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_p = '0;
   logic [15:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_q, out_r;
   logic        out_dbz, out_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   wt16_divider #(.N(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   // Issue one request and wait (bounded) for out_valid; does not hand off the result.
   task automatic run_op(input logic [31:0] p, input logic [15:0] b,
                         output logic rdy, output int lat,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dbz, output logic ovf);
      @(negedge clk);
      in_valid = 1'b1; in_p = p; in_b = b;
      rdy = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         n_checks++; n_fail++;
         $display("FAIL timeout: out_valid never rose for p=%h b=%h", p, b);
      end
      q = out_q; r = out_r; dbz = out_dbz; ovf = out_ovf;
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if ({out_q, out_r} !== 32'h0) begin n_fail++; $display("FAIL reset_qr: got %h/%h want 0/0", out_q, out_r); end
      n_checks++; if ({out_dbz, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", out_dbz, out_ovf); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] p [4] = '{32'h0626_0060, 32'h0000_0064, 32'hFFFE_0001, 32'h0000_0000};
      logic [15:0] b [4] = '{16'h5678, 16'h0007, 16'hFFFF, 16'h0001};
      logic [15:0] eq [4] = '{16'h1234, 16'h000E, 16'hFFFF, 16'h0000};
      logic [15:0] er [4] = '{16'h0000, 16'h0002, 16'h0000, 16'h0000};
      logic rdy, dbz, ovf; int lat; logic [15:0] q, r;
      for (int i = 0; i < 4; i++) begin
         run_op(p[i], b[i], rdy, lat, q, r, dbz, ovf);
         n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL dir%0d_ready: got %b want 1", i, rdy); end
         n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
         n_checks++; if (q !== eq[i] || r !== er[i]) begin n_fail++; $display("FAIL dir%0d_qr: got %h/%h want %h/%h", i, q, r, eq[i], er[i]); end
         n_checks++; if ({dbz, ovf} !== 2'b00) begin n_fail++; $display("FAIL dir%0d_flags: got %b%b want 00", i, dbz, ovf); end
         take_result();
         n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_handoff: got valid=%b ready=%b want 0/1", i, out_valid, in_ready); end
      end
   endtask

   task automatic test_errors();
      logic rdy, dbz, ovf; int lat; logic [15:0] q, r;
      run_op(32'h0001_2345, 16'h0000, rdy, lat, q, r, dbz, ovf);
      n_checks++; if (lat != 0) begin n_fail++; $display("FAIL dbz_latency: got %0d want 0", lat); end
      n_checks++; if (q !== 16'hFFFF || r !== 16'h2345) begin n_fail++; $display("FAIL dbz_qr: got %h/%h want ffff/2345", q, r); end
      n_checks++; if ({dbz, ovf} !== 2'b10) begin n_fail++; $display("FAIL dbz_flags: got %b%b want 10", dbz, ovf); end
      take_result();
      run_op(32'h0001_0000, 16'h0001, rdy, lat, q, r, dbz, ovf);
      n_checks++; if (lat != 0) begin n_fail++; $display("FAIL ovf_latency: got %0d want 0", lat); end
      n_checks++; if (q !== 16'hFFFF || r !== 16'h0000) begin n_fail++; $display("FAIL ovf_qr: got %h/%h want ffff/0000", q, r); end
      n_checks++; if ({dbz, ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags: got %b%b want 01", dbz, ovf); end
      take_result();
      // high half one below divisor is the largest non-overflow dividend
      run_op(32'h0006_FFFF, 16'h0007, rdy, lat, q, r, dbz, ovf);
      n_checks++; if (q !== 16'hFFFF || r !== 16'h0006 || {dbz, ovf} !== 2'b00) begin n_fail++; $display("FAIL edge_qr: got %h/%h %b%b want ffff/0006 00", q, r, dbz, ovf); end
      take_result();
   endtask

   task automatic test_backpressure();
      logic rdy, dbz, ovf; int lat; logic [15:0] q, r;
      run_op(32'h0000_0064, 16'h0007, rdy, lat, q, r, dbz, ovf);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_p = 32'h0000_0010; in_b = 16'h0003;
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d_hs: got valid=%b ready=%b want 1/0", i, out_valid, in_ready); end
         n_checks++; if (out_q !== 16'h000E || out_r !== 16'h0002) begin n_fail++; $display("FAIL hold%0d_qr: got %h/%h want 000e/0002", i, out_q, out_r); end
      end
      in_valid = 1'b0;
      take_result();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_back_to_back();
      logic rdy, dbz, ovf; int lat; logic [15:0] q, r;
      run_op(32'h0000_0064, 16'h0007, rdy, lat, q, r, dbz, ovf);
      take_result();
      run_op(32'h0626_0060, 16'h5678, rdy, lat, q, r, dbz, ovf);
      n_checks++; if (rdy !== 1'b1 || lat != LAT || q !== 16'h1234 || r !== 16'h0000) begin n_fail++; $display("FAIL b2b: got rdy=%b lat=%0d q=%h r=%h want 1/%0d/1234/0000", rdy, lat, q, r, LAT); end
      take_result();
   endtask

   task automatic test_abort();
      logic rdy, dbz, ovf; int lat; logic [15:0] q, r;
      @(negedge clk);
      in_valid = 1'b1; in_p = 32'h0626_0060; in_b = 16'h5678;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (LAT / 2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_state: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
      @(negedge clk); rst = 1'b0;
      run_op(32'h0000_0064, 16'h0007, rdy, lat, q, r, dbz, ovf);
      n_checks++; if (lat != LAT || q !== 16'h000E || r !== 16'h0002) begin n_fail++; $display("FAIL abort_recover: got lat=%0d q=%h r=%h want %0d/000e/0002", lat, q, r, LAT); end
      take_result();
   endtask

   task automatic test_random();
      logic rdy, dbz, ovf; int lat; logic [15:0] q, r, b, hi, lo;
      logic [31:0] p, eq, er;
      for (int i = 0; i < 200; i++) begin
         b  = 16'($urandom_range(1, 65535));
         hi = 16'($urandom % b);
         lo = 16'($urandom);
         p  = {hi, lo};
         eq = p / {16'h0, b};
         er = p % {16'h0, b};
         run_op(p, b, rdy, lat, q, r, dbz, ovf);
         n_checks++;
         if ({16'h0, q} !== eq || {16'h0, r} !== er || {dbz, ovf} !== 2'b00 || lat != LAT) begin
            n_fail++;
            $display("FAIL rand%0d p=%h b=%h: got %h/%h %b%b lat=%0d want %h/%h 00 lat=%0d", i, p, b, q, r, dbz, ovf, lat, eq[15:0], er[15:0], LAT);
         end
         take_result();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
